ucsbece154a_uart_tx: RTL and testbench
======================================

# ucsbece154a_uart_tx

Memory-mapped UART transmitter on the core's data bus, next to data memory. It consumes word stores that the top-level address decode routes to it, buffers bytes in a small FIFO, and serialises them 8N1, LSB first, on `tx_o`. Software polls a status register for FIFO and transmit state. The processor needs no stall logic, because overflowing writes are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries; must be a power of two, ≥ 2.
- `clk` (input, 1): clock. All state changes on rising edge.
- `reset` (input, 1): synchronous, active-high.
- `sel_i` (input, 1): bus select from the top-level address decode.
- `a_i` (input, 4): byte offset within the peripheral window. Bits [3:2] select the register; bits [1:0] are ignored.
- `we_i` (input, 1): write enable, valid with `sel_i`.
- `wd_i` (input, 32): write data.
- `rd_o` (output, 32): combinational read data. Reads 0 when `sel_i`=0.
- `tx_o` (output, 1): serial line; idles high.

## Operation
- Register map:
  - 0x0 TXDATA. Write pushes `wd_i[7:0]`. Reads 0.
  - 0x4 STATUS, read-only except bit 3. Fields:
    - bit0 full
    - bit1 empty
    - bit2 busy: FSM not in IDLE
    - bit3 overflow: sticky; any write to STATUS clears it
    - bits[7:4] FIFO count
    - all other bits 0
  - 0x8 CTRL. bit0 enable, reset value 1.
  - 0xC reads 0; writes ignored.
- Push:
  - Occurs when `sel_i & we_i` and offset is 0x0.
  - Accepted if not full, or if full and a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overflow is set.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE: `tx_o`=1. If enable=1 and FIFO non-empty, pop the head into the shift register and go to START.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx_o`=shift[0] for `CLKS_PER_BIT` cycles per bit. Shift right after each bit. After bit 7 go to STOP (or PARITY).
  - STOP: `tx_o`=1 for `CLKS_PER_BIT` cycles.
    - If enable=1 and FIFO non-empty at the last STOP cycle: pop and go directly to START, giving back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Clearing enable mid-frame does not abort the frame. It only blocks the next pop.
- Counters:
  - Bit counter: 3 bits; wraps from 7 to 0.
  - Baud counter: clog2(`CLKS_PER_BIT`) bits; counts down and reloads with `CLKS_PER_BIT`-1 at each state/bit boundary.
  - FIFO pointers: clog2(`FIFO_DEPTH`) bits; wrap naturally.
  - FIFO count: clog2(`FIFO_DEPTH`)+1 bits; STATUS shows it zero-extended or truncated to 4 bits.

## Timing
- Reset values:
  - `tx_o`=1
  - FSM IDLE
  - FIFO empty, count 0
  - overflow 0
  - enable 1
  - `rd_o`=0 while unselected
- A reset asserted mid-frame returns `tx_o` to 1 on the next edge and discards FIFO contents.
- Push-to-line latency from idle: push at edge N, START entered at edge N+1, so `tx_o` falls after edge N+1.
- Frame length is 10·`CLKS_PER_BIT` cycles; 11·`CLKS_PER_BIT` with parity.
- STATUS reflects register state after the most recent edge. There is no read side effect.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - It drives the even parity of the 8 data bits for `CLKS_PER_BIT` cycles.
  - CTRL bit1 selects odd parity (reset 0).
- Macro undefined:
  - No PARITY state.
  - CTRL bit1 reads 0; writes to it are ignored.

## Structure
- Shared package `ucsbece154a_uart_pkg` holds:
  - register offset constants (`TXDATA_OFF`, `STATUS_OFF`, `CTRL_OFF`)
  - STATUS bit index constants
  - FSM state typedef/encoding
- One sub-module: `ucsbece154a_uart_fifo`, a synchronous FIFO with push/pop, full/empty and count outputs. The FSM, baud counter and register decode live in the top block.

## Test plan
- Write 0x55 to TXDATA after reset (`CLKS_PER_BIT`=4) → `tx_o` emits 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then idles high; STATUS reads 0x2 afterwards.
- Write 0xA1, 0x0F back-to-back → two frames with no idle cycle between STOP and the second START; busy stays 1 throughout.
- Write 6 bytes in 6 consecutive cycles with the FSM idle (`FIFO_DEPTH`=4):
  - first byte is popped immediately;
  - next 4 fill the FIFO;
  - 6th byte is dropped;
  - STATUS shows full=1, overflow=1, count=4;
  - writing STATUS clears overflow only.
- Clear CTRL enable, write 0x33 → no frame, STATUS count=1. Set enable → frame starts the next cycle.
- Assert `reset` during DATA bit 3 → `tx_o`=1 after the edge, STATUS=0x2, and no further frame.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit 1 (even); with CTRL bit1 set, parity bit 0; frame 44 cycles.

Source files
------------

// File: rtl/ucsbece154a_uart_pkg.sv
// UART TX shared definitions: register offsets, STATUS bit
// indices and FSM state encoding. No ports.
package ucsbece154a_uart_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] CTRL_OFF   = 4'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_STOP   = 3'd3;
    localparam state_t S_PARITY = 3'd4;

    function automatic logic [1:0] reg_idx(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/ucsbece154a_uart_tx_if.sv
// UART TX bus interface: sel_i, a_i, we_i, wd_i from the core,
// rd_o back. master = core side, slave = peripheral side.
interface ucsbece154a_uart_tx_if;
    logic        sel_i;
    logic [3:0]  a_i;
    logic        we_i;
    logic [31:0] wd_i;
    logic [31:0] rd_o;

    modport master (
        output sel_i, a_i, we_i, wd_i,
        input  rd_o
    );

    modport slave (
        input  sel_i, a_i, we_i, wd_i,
        output rd_o
    );
endinterface

// File: rtl/ucsbece154a_uart_fifo.sv
// Synchronous byte FIFO. Ports: clk, reset, push_i/pop_i,
// wdata_i, rdata_o (head), full_o, empty_o, count_o.
module ucsbece154a_uart_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [7:0]   wdata_i,
    output logic [7:0]   rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // a push into a full FIFO is legal when the head leaves
    // in the same cycle; wptr == rptr then, and the read
    // sees the old head before the write lands.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q
                     + (AW+1)'(push_ok)
                     - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/ucsbece154a_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Ports: clk, reset,
// bus (slave: sel_i a_i we_i wd_i rd_o), tx_o serial line.
// Optional macro UART_TX_PARITY_EN adds a parity bit and
// CTRL bit1 (odd parity).
module ucsbece154a_uart_tx
    import ucsbece154a_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ucsbece154a_uart_tx_if.slave bus,
    output logic                 tx_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          en_q, en_d;
    logic          ovf_q, ovf_d;
    logic          odd_q, par_q;

    logic          full, empty, pop;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          wr, wr_tx, wr_st, wr_ctrl;
    logic          baud_done, start_frame;
    logic          is_tx, is_st, is_ctrl;
    logic [31:0]   status, ctrl;
    logic          unused_ok;

    assign unused_ok = ^{bus.wd_i[31:8], bus.a_i[1:0]};

    assign is_tx   = bus.a_i[3:2] == reg_idx(TXDATA_OFF);
    assign is_st   = bus.a_i[3:2] == reg_idx(STATUS_OFF);
    assign is_ctrl = bus.a_i[3:2] == reg_idx(CTRL_OFF);

    assign wr      = bus.sel_i & bus.we_i;
    assign wr_tx   = wr & is_tx;
    assign wr_st   = wr & is_st;
    assign wr_ctrl = wr & is_ctrl;

    ucsbece154a_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_tx),
        .pop_i   (pop),
        .wdata_i (bus.wd_i[7:0]),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign baud_done = (baud_q == '0);

    // a new frame starts from IDLE or straight out of the
    // last STOP cycle, which removes the inter-frame gap
    assign start_frame = en_q & ~empty &
        ((state_q == S_IDLE) |
         ((state_q == S_STOP) & baud_done));
    assign pop = start_frame;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: ;
            S_START: begin
                baud_d = baud_q - BW'(1);
                if (baud_done) begin
                    state_d = S_DATA;
                    baud_d  = RELOAD;
                end
            end
            S_DATA: begin
                baud_d = baud_q - BW'(1);
                if (baud_done) begin
                    baud_d  = RELOAD;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = baud_q - BW'(1);
                if (baud_done) begin
                    state_d = S_STOP;
                    baud_d  = RELOAD;
                end
            end
`endif
            S_STOP: begin
                baud_d = baud_q - BW'(1);
                if (baud_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (start_frame) begin
            state_d = S_START;
            baud_d  = RELOAD;
            shift_d = head;
        end
    end

    // overflow only when a push finds no room even after
    // the same-cycle pop
    assign ovf_d = wr_st ? 1'b0 :
                   (ovf_q | (wr_tx & full & ~pop));
    assign en_d  = wr_ctrl ? bus.wd_i[0] : en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            en_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // parity is latched with the byte so a CTRL write
    // mid-frame cannot corrupt the frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            odd_q <= 1'b0;
            par_q <= 1'b0;
        end else begin
            if (wr_ctrl)     odd_q <= bus.wd_i[1];
            if (start_frame) par_q <= ^head ^ odd_q;
        end
    end
`else
    assign odd_q = 1'b0;
    assign par_q = 1'b1;
`endif

    always_comb begin
        unique case (state_q)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = shift_q[0];
            S_PARITY: tx_o = par_q;
            default:  tx_o = 1'b1;
        endcase
    end

    always_comb begin
        status = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = (state_q != S_IDLE);
        status[ST_OVF]   = ovf_q;
        status[ST_CNT_LSB +: 4] = 4'(count);
    end

    assign ctrl = {30'b0, odd_q, en_q};

    always_comb begin
        bus.rd_o = '0;
        if (bus.sel_i) begin
            unique case (1'b1)
                is_st:   bus.rd_o = status;
                is_ctrl: bus.rd_o = ctrl;
                default: bus.rd_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ucsbece154a_uart_tx.sv
// Self-checking bench for ucsbece154a_uart_tx: directed
// scenarios plus random bus traffic against a frame model.
module tb_ucsbece154a_uart_tx;
    localparam int CPB = 4;
    localparam int D   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    int   tests = 0;
    int   fails = 0;

    ucsbece154a_uart_tx_if bus ();

    ucsbece154a_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .tx_o  (tx)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    int         pos;
    logic [7:0] cur;
    logic       par, m_ovf, m_en, m_odd;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] d,
                                  input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && NB == 11) return p;
        return 1'b1;
    endfunction

    function automatic logic exp_tx();
        if (pos < 0) return 1'b1;
        return fbit(cur, par, pos / CPB);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] st;
        st = '0;
        st[0]   = (q.size() == D);
        st[1]   = (q.size() == 0);
        st[2]   = (pos >= 0);
        st[3]   = m_ovf;
        st[7:4] = 4'(q.size());
        case (a[3:2])
            2'd1:    return st;
            2'd2:    return {30'b0, m_odd, m_en};
            default: return 32'b0;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic s,
                       input logic w, input logic [3:0] a,
                       input logic [31:0] d);
        logic p;
        reset     = rst;
        bus.sel_i = s;
        bus.we_i  = w;
        bus.a_i   = a;
        bus.wd_i  = d;
        #1;
        chk("rd", bus.rd_o, s ? m_read(a) : 32'b0);
        if (rst) begin
            q.delete();
            pos = -1; m_ovf = 0; m_en = 1; m_odd = 0;
        end else begin
            p = m_en && q.size() > 0 &&
                (pos < 0 || pos == FRAME - 1);
            if (p) begin
                cur = q.pop_front();
                par = ^cur ^ m_odd;
                pos = 0;
            end else if (pos >= 0) begin
                pos++;
                if (pos == FRAME) pos = -1;
            end
            if (s && w) begin
                case (a[3:2])
                    2'd0: if (q.size() < D) q.push_back(d[7:0]);
                          else m_ovf = 1;
                    2'd1: m_ovf = 0;
                    2'd2: begin
                        m_en = d[0];
`ifdef UART_TX_PARITY_EN
                        m_odd = d[1];
`endif
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'h0, 0);
    endtask

    task automatic peek(input logic [3:0] a,
                        input logic [31:0] exp,
                        input string tag);
        bus.sel_i = 1; bus.we_i = 0; bus.a_i = a;
        #1;
        chk(tag, bus.rd_o, exp);
        bus.sel_i = 0;
    endtask

    initial begin
        logic [7:0] v;
        int r;
        pos = -1; m_ovf = 0; m_en = 1; m_odd = 0;
        cur = 0; par = 0;
        reset = 1; bus.sel_i = 0; bus.we_i = 0;
        bus.a_i = 0; bus.wd_i = 0;
        cyc(1, 0, 0, 4'h0, 0);
        cyc(1, 0, 0, 4'h0, 0);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        peek(4'h4, 32'h2, "rst_status");
        peek(4'h8, 32'h1, "rst_ctrl");
        bus.a_i = 4'h4; #1;
        chk("rd_unsel", bus.rd_o, 32'h0);

        v = 8'h55;
        cyc(0, 1, 1, 4'h0, 32'h55);
        for (int k = 0; k < FRAME; k++) begin
            cyc(0, 0, 0, 4'h0, 0);
            chk("t1_bit", {31'b0, tx},
                {31'b0, fbit(v, ^v, k / CPB)});
        end
        cyc(0, 0, 0, 4'h0, 0);
        peek(4'h4, 32'h2, "t1_status");

        cyc(0, 1, 1, 4'h0, 32'hA1);
        cyc(0, 1, 1, 4'h0, 32'h0F);
        for (int i = 0; i < 2 * FRAME; i++) begin
            bus.sel_i = 1; bus.we_i = 0; bus.a_i = 4'h4;
            #1;
            chk("t2_busy", {31'b0, bus.rd_o[2]}, 32'd1);
            cyc(0, 1, 0, 4'h4, 0);
        end
        idle(3);

        for (int i = 0; i < 6; i++)
            cyc(0, 1, 1, 4'h0, $urandom_range(0, 255));
        peek(4'h4, 32'h4D, "t3_full_ovf");
        cyc(0, 1, 1, 4'h4, 32'h0);
        peek(4'h4, 32'h45, "t3_ovf_clr");
        idle(5 * FRAME + 4);

        cyc(0, 1, 1, 4'h8, 32'h0);
        cyc(0, 1, 1, 4'h0, 32'h33);
        idle(3);
        peek(4'h4, 32'h10, "t4_held");
        peek(4'h8, 32'h0, "t4_ctrl");
        cyc(0, 1, 1, 4'h8, 32'h1);
        cyc(0, 0, 0, 4'h0, 0);
        chk("t4_start", {31'b0, tx}, 32'd0);
        idle(FRAME + 2);

        cyc(0, 1, 1, 4'h0, 32'h5A);
        cyc(0, 1, 1, 4'h0, 32'h11);
        idle(17);
        cyc(1, 0, 0, 4'h0, 0);
        chk("t5_tx", {31'b0, tx}, 32'd1);
        peek(4'h4, 32'h2, "t5_status");
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 0, 0, 4'h0, 0);
            chk("t5_quiet", {31'b0, tx}, 32'd1);
        end

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 7)
                cyc(0, 1, 1, 4'(4'h0 | 4'($urandom_range(0, 3))),
                    $urandom);
            else if (r < 9)
                cyc(0, 1, 1, 4'h4, $urandom);
            else if (r < 11)
                cyc(0, 1, 1, 4'h8,
                    {$urandom_range(0, 3) != 0 ? 31'h1 : 31'h0,
                     1'b0} >> 1 | 32'($urandom_range(0, 1) << 1));
            else if (r < 12)
                cyc(0, 1, 1, 4'hC, $urandom);
            else if (r < 13)
                cyc(1, 0, 0, 4'h0, 0);
            else if (r < 45)
                cyc(0, 1, 0, 4'($urandom_range(0, 15)), 0);
            else
                cyc(0, 0, 0, 4'h0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
